pc_sequencer: RTL and testbench

//  Owns the architectural PC: holds the PC register, selects the next PC each cycle from PC+2,
//  a PC-relative branch target (B) or a register target (BR), and sequences stall/halt/flush.

---
 rtl/wisc_pkg.sv | 26 ++
 rtl/PSA_16bit.sv | 11 +
 rtl/branch_cond.sv | 31 +++
 rtl/pc_sequencer.sv | 128 ++++++++++++
 tb/tb_pc_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/wisc_pkg.sv
// Shared types and constants for the WISC fetch/sequencing logic.
package wisc_pkg;

  localparam int PC_W = 16;

  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    NE  = 3'b000,
    EQ  = 3'b001,
    GT  = 3'b010,
    LT  = 3'b011,
    GE  = 3'b100,
    LE  = 3'b101,
    OV  = 3'b110,
    UNC = 3'b111
  } ccc_e;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } seq_state_e;

endpackage

// File: rtl/PSA_16bit.sv
// 16-bit add/subtract (A + B, or A - B when Sub=1), result wraps mod 2^16.
module PSA_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Sub,
  output logic [15:0] Sum
);

  assign Sum = A + (B ^ {16{Sub}}) + {15'b0, Sub};

endmodule

// File: rtl/branch_cond.sv
// Evaluates a branch condition code against the {V,N,Z} flag register.
module branch_cond
  import wisc_pkg::*;
(
  input  logic [2:0] ccc,
  input  logic [2:0] flags,
  output logic       cond
);

  logic v, n, z;

  assign v = flags[FLAG_V];
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];

  always_comb begin
    cond = 1'b0;
    case (ccc_e'(ccc))
      NE:      cond = ~z;
      EQ:      cond = z;
      GT:      cond = ~z & ~n;
      LT:      cond = n;
      GE:      cond = z | (~z & ~n);
      LE:      cond = z | n;
      OV:      cond = v;
      UNC:     cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC owner: next-PC select (PC+2 / B / BR), stall, halt, flush, perf counters.
//   state  | meaning
//   RUN    | fetching; PC advances, redirects on taken branch, holds on stall
//   HALTED | HLT retired; PC frozen until reset
module pc_sequencer
  import wisc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_valid,
  input  logic             br_reg,
  input  logic [2:0]       ccc,
  input  logic [8:0]       imm,
  input  logic [2:0]       flags,
  input  logic [PC_W-1:0]  reg_target,
  input  logic [PC_W-1:0]  id_pc,
  input  logic             hlt,
  output logic [PC_W-1:0]  pc,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] br_taken_cnt,
  output logic [CNT_W-1:0] fetch_cnt
);

  seq_state_e       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;

  logic            cond;
  logic            taken;
  logic            flush_c;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] b_target;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] b_offset;

  branch_cond u_branch_cond (
    .ccc   (ccc),
    .flags (flags),
    .cond  (cond)
  );

  // Word offset -> byte offset: sign-extend the 9-bit immediate and shift left by one.
  assign b_offset = {{6{imm[8]}}, imm, 1'b0};

  PSA_16bit u_pc_inc (
    .A   (pc_q),
    .B   (16'h0002),
    .Sub (1'b0),
    .Sum (pc_inc)
  );

  PSA_16bit u_b_target (
    .A   (id_pc),
    .B   (b_offset),
    .Sub (1'b0),
    .Sum (b_target)
  );

  assign br_target = br_reg ? reg_target : b_target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush_c = 1'b0;
    taken   = 1'b0;
    case (state_q)
      RUN: begin
        if (hlt && !stall) begin
          state_d = HALTED;
          flush_c = 1'b1;
        end else if (stall) begin
          pc_d = pc_q;
        end else if ((br_valid || br_reg) && cond) begin
          taken   = 1'b1;
          flush_c = 1'b1;
          pc_d    = br_target;
        end else begin
          pc_d = pc_inc;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_comb begin
    br_cnt_d    = br_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    if (taken && (br_cnt_q != {CNT_W{1'b1}})) begin
      br_cnt_d = br_cnt_q + CNT_W'(1);
    end
    // A redirect to the current PC does not count as an advance.
    if ((pc_d != pc_q) && (fetch_cnt_q != {CNT_W{1'b1}})) begin
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      br_cnt_q    <= '0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      br_cnt_q    <= br_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign pc           = pc_q;
  assign flush        = flush_c & ~rst;
  assign halted       = (state_q == HALTED);
  assign br_taken_cnt = br_cnt_q;
  assign fetch_cnt    = fetch_cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: per-cycle expectations queued at drive time, checked after the edge.
module tb_pc_sequencer;

  localparam int CNT_W = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic        br_reg;
  logic [2:0]  ccc;
  logic [8:0]  imm;
  logic [2:0]  flags;
  logic [15:0] reg_target;
  logic [15:0] id_pc;
  logic        hlt;
  logic [15:0] pc;
  logic        flush;
  logic        halted;
  logic [CNT_W-1:0] br_taken_cnt;
  logic [CNT_W-1:0] fetch_cnt;

  pc_sequencer #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_reg       (br_reg),
    .ccc          (ccc),
    .imm          (imm),
    .flags        (flags),
    .reg_target   (reg_target),
    .id_pc        (id_pc),
    .hlt          (hlt),
    .pc           (pc),
    .flush        (flush),
    .halted       (halted),
    .br_taken_cnt (br_taken_cnt),
    .fetch_cnt    (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            tag;
    logic             flush;
    logic [15:0]      pc;
    logic             halted;
    logic [CNT_W-1:0] brc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0]      m_pc;
  logic             m_halted;
  logic [CNT_W-1:0] m_brc;
  logic [CNT_W-1:0] m_fc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_cond(input logic [2:0] c, input logic [2:0] f);
    logic v, n, z;
    v = f[2]; n = f[1]; z = f[0];
    case (c)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || (!z && !n);
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  // Caller has set the inputs just after a rising edge; this models the cycle,
  // queues the expectation, samples flush mid-cycle and checks after the next edge.
  task automatic step(input string tag);
    exp_t        e;
    logic [15:0] nxt;
    logic        obs_flush;
    e.tag   = tag;
    e.flush = 1'b0;
    if (rst) begin
      m_pc = RESET_PC; m_halted = 1'b0; m_brc = '0; m_fc = '0;
    end else if (!m_halted) begin
      nxt = m_pc;
      if (hlt && !stall) begin
        m_halted = 1'b1;
        e.flush  = 1'b1;
      end else if (stall) begin
        nxt = m_pc;
      end else if ((br_valid || br_reg) && ref_cond(ccc, flags)) begin
        e.flush = 1'b1;
        if (br_reg) nxt = reg_target;
        else        nxt = 16'(id_pc + 16'(signed'(imm)) * 16'd2);
        if (m_brc != '1) m_brc = m_brc + 1'b1;
      end else begin
        nxt = 16'(m_pc + 16'd2);
      end
      if (nxt != m_pc && m_fc != '1) m_fc = m_fc + 1'b1;
      m_pc = nxt;
    end
    e.pc = m_pc; e.halted = m_halted; e.brc = m_brc; e.fc = m_fc;
    exp_q.push_back(e);
    #2;
    obs_flush = flush;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, " flush"},  32'(obs_flush),    32'(e.flush));
    chk({e.tag, " pc"},     32'(pc),           32'(e.pc));
    chk({e.tag, " halted"}, 32'(halted),       32'(e.halted));
    chk({e.tag, " brcnt"},  32'(br_taken_cnt), 32'(e.brc));
    chk({e.tag, " fcnt"},   32'(fetch_cnt),    32'(e.fc));
  endtask

  task automatic idle();
    rst = 0; stall = 0; br_valid = 0; br_reg = 0; hlt = 0;
    ccc = 3'd0; imm = 9'd0; flags = 3'd0; reg_target = 16'd0; id_pc = 16'd0;
  endtask

  initial begin
    idle();
    m_pc = RESET_PC; m_halted = 0; m_brc = '0; m_fc = '0;
    rst = 1;
    @(posedge clk); #1;

    rst = 1; step("reset1");
    rst = 1; stall = 1; br_reg = 1; ccc = 3'd7; step("reset2");
    idle(); step("run1");
    step("run2");

    // B EQ taken: 0x0010 + (-4 << 1) = 0x0008
    idle(); br_valid = 1; id_pc = 16'h0010; imm = 9'h1FC; flags = 3'b001; ccc = 3'b001;
    step("b_eq");
    idle(); br_valid = 1; ccc = 3'b000; flags = 3'b001; step("b_ne_nt");

    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        idle();
        br_valid = 1; ccc = 3'(c); flags = 3'(f);
        id_pc = 16'($urandom); imm = 9'($urandom);
        step($sformatf("cond c%0d f%0d", c, f));
      end
    end

    // BR held off by stall, then taken when released.
    idle(); br_reg = 1; ccc = 3'd7; reg_target = 16'h1234; stall = 1;
    step("br_stall1");
    step("br_stall2");
    stall = 0; step("br_release");
    idle(); step("after_br");

    // Both branch kinds valid: register target wins.
    idle(); br_valid = 1; br_reg = 1; ccc = 3'd7; reg_target = 16'h0100;
    id_pc = 16'h4000; imm = 9'h004; step("br_wins");

    // PC wrap at 0xFFFE.
    idle(); br_reg = 1; ccc = 3'd7; reg_target = 16'hFFFE; step("to_fffe");
    idle(); step("wrap");
    idle(); br_valid = 1; ccc = 3'd7; id_pc = 16'hFF00; imm = 9'h0FF; step("tgt_wrap");

    // Halt with a concurrent taken branch; halt wins and squashes.
    idle(); hlt = 1; br_valid = 1; ccc = 3'd7; id_pc = 16'h2000; imm = 9'h010;
    step("hlt");
    for (int i = 0; i < 10; i++) begin
      idle();
      stall = 1'($urandom); br_valid = 1; br_reg = 1'($urandom); ccc = 3'd7;
      hlt = 1'($urandom); reg_target = 16'($urandom); id_pc = 16'($urandom);
      step($sformatf("halted%0d", i));
    end
    idle(); rst = 1; hlt = 1; step("hlt_reset");
    idle(); step("post_reset");

    // Counter saturation after reset.
    for (int i = 0; i < 20; i++) begin
      idle(); br_valid = 1; ccc = 3'd7; id_pc = 16'(i * 16); imm = 9'h002;
      step($sformatf("sat%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
